// File: rtl/riscv_mstage_lsu.sv
// -----------------------------------------------------------------------------
// riscv_mstage_lsu
//
// Memory-stage load/store unit. Takes the execute-stage ALU result as the
// effective address and rs2 as store data, runs a request/grant/response
// exchange with data memory, aligns byte lanes, sign/zero-extends loads and
// stalls the pipeline until the access has completed.
//
// Optional build macro: RISCV_MSTAGE_MISALIGN_CHK_EN
//   defined   : an access not naturally aligned to its size raises
//               o_riscv_mstage_misaligned in IDLE and is not issued.
//   undefined : o_riscv_mstage_misaligned is tied 0 and the low address bits
//               below the access size are cleared (access forced aligned).
//
// Ports
//   i_riscv_clk / i_riscv_rst        clock, synchronous active-high reset
//   i_riscv_mstage_*                 op from the E/M register (valid, read,
//                                    write, funct3, address, store data)
//   o_riscv_mstage_stall             freeze PC/IF/ID/EX/EM registers
//   o_riscv_mstage_rdata(_valid)     extended load result + 1-cycle strobe
//   o_riscv_mstage_misaligned        misaligned access flag
//   o_riscv_dmem_*                   request, write enable, aligned address,
//                                    lane-shifted data, byte mask
//   i_riscv_dmem_gnt/rvalid/rdata    grant, read-data valid, read data
//
// Memory handshake: req is held high with addr/wdata/bytemask/we stable until
// the cycle gnt is sampled high; the request is accepted on that edge. For a
// load, read data is taken on the first cycle rvalid is high after the grant.
// gnt and rvalid arriving in any other state are ignored.
// -----------------------------------------------------------------------------
module riscv_mstage_lsu #(
    parameter int XLEN       = 64,
    parameter int DMEM_BYTES = XLEN / 8
) (
    input  logic                  i_riscv_clk,
    input  logic                  i_riscv_rst,
    input  logic                  i_riscv_mstage_valid,
    input  logic                  i_riscv_mstage_memread,
    input  logic                  i_riscv_mstage_memwrite,
    input  logic [2:0]            i_riscv_mstage_funct3,
    input  logic [XLEN-1:0]       i_riscv_mstage_addr,
    input  logic [XLEN-1:0]       i_riscv_mstage_wdata,
    output logic                  o_riscv_mstage_stall,
    output logic [XLEN-1:0]       o_riscv_mstage_rdata,
    output logic                  o_riscv_mstage_rdata_valid,
    output logic                  o_riscv_mstage_misaligned,
    output logic                  o_riscv_dmem_req,
    output logic                  o_riscv_dmem_we,
    output logic [XLEN-1:0]       o_riscv_dmem_addr,
    output logic [XLEN-1:0]       o_riscv_dmem_wdata,
    output logic [DMEM_BYTES-1:0] o_riscv_dmem_bytemask,
    input  logic                  i_riscv_dmem_gnt,
    input  logic                  i_riscv_dmem_rvalid,
    input  logic [XLEN-1:0]       i_riscv_dmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic [2:0]            funct3_q;
    logic [2:0]            off_q;

    logic                  mem_op;
    logic                  start;
    logic [1:0]            size;
    logic [2:0]            low_mask;
    logic [2:0]            off_in;
    logic [DMEM_BYTES-1:0] base_mask;
    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       load_ext;

    assign mem_op = i_riscv_mstage_valid &
                    (i_riscv_mstage_memread | i_riscv_mstage_memwrite);
    assign size   = i_riscv_mstage_funct3[1:0];

    // Address bits that must be zero for a naturally aligned access.
    always_comb begin
        case (size)
            2'd0:    low_mask = 3'b000;
            2'd1:    low_mask = 3'b001;
            2'd2:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
    end

    always_comb begin
        case (size)
            2'd0:    base_mask = DMEM_BYTES'(8'h01);
            2'd1:    base_mask = DMEM_BYTES'(8'h03);
            2'd2:    base_mask = DMEM_BYTES'(8'h0F);
            default: base_mask = DMEM_BYTES'(8'hFF);
        endcase
    end

`ifdef RISCV_MSTAGE_MISALIGN_CHK_EN
    logic mis_hit;
    assign mis_hit = |(i_riscv_mstage_addr[2:0] & low_mask);
    assign off_in  = i_riscv_mstage_addr[2:0];
    assign start   = (state == S_IDLE) & mem_op & ~mis_hit;
    assign o_riscv_mstage_misaligned = (state == S_IDLE) & mem_op & mis_hit;
`else
    // Misaligned offsets are rounded down to the access size.
    assign off_in  = i_riscv_mstage_addr[2:0] & ~low_mask;
    assign start   = (state == S_IDLE) & mem_op;
    assign o_riscv_mstage_misaligned = 1'b0;
`endif

    // Load data: move the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = i_riscv_dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge i_riscv_clk) begin
        if (i_riscv_rst) begin
            state                      <= S_IDLE;
            funct3_q                   <= '0;
            off_q                      <= '0;
            o_riscv_dmem_we            <= 1'b0;
            o_riscv_dmem_addr          <= '0;
            o_riscv_dmem_wdata         <= '0;
            o_riscv_dmem_bytemask      <= '0;
            o_riscv_mstage_rdata       <= '0;
            o_riscv_mstage_rdata_valid <= 1'b0;
        end else begin
            o_riscv_mstage_rdata_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state                 <= S_REQ;
                        funct3_q              <= i_riscv_mstage_funct3;
                        off_q                 <= off_in;
                        // Read+write together is treated as a store.
                        o_riscv_dmem_we       <= i_riscv_mstage_memwrite;
                        o_riscv_dmem_addr     <= {i_riscv_mstage_addr[XLEN-1:3], 3'b000};
                        o_riscv_dmem_wdata    <= i_riscv_mstage_wdata << {off_in, 3'b000};
                        o_riscv_dmem_bytemask <= base_mask << off_in;
                    end
                end
                S_REQ: begin
                    if (i_riscv_dmem_gnt) begin
                        state <= o_riscv_dmem_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_riscv_dmem_rvalid) begin
                        o_riscv_mstage_rdata       <= load_ext;
                        o_riscv_mstage_rdata_valid <= 1'b1;
                        state                      <= S_DONE;
                    end
                end
                // The op is still in E/M during DONE; returning to IDLE here
                // and releasing stall lets it leave without being re-issued.
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_riscv_dmem_req = (state == S_REQ);

    always_comb begin
        o_riscv_mstage_stall = 1'b0;
        if (!i_riscv_rst) begin
            case (state)
                S_IDLE:  o_riscv_mstage_stall = start;
                S_REQ:   o_riscv_mstage_stall = 1'b1;
                S_WAIT:  o_riscv_mstage_stall = 1'b1;
                default: o_riscv_mstage_stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mstage_lsu.sv
module tb_riscv_mstage_lsu;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        stall;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        req;
    logic        we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  bytemask;
    logic        gnt;
    logic        rvalid;
    logic [63:0] dmem_rdata;

    riscv_mstage_lsu #(.XLEN(64), .DMEM_BYTES(8)) dut (
        .i_riscv_clk                (clk),
        .i_riscv_rst                (rst),
        .i_riscv_mstage_valid       (valid),
        .i_riscv_mstage_memread     (memread),
        .i_riscv_mstage_memwrite    (memwrite),
        .i_riscv_mstage_funct3      (funct3),
        .i_riscv_mstage_addr        (addr),
        .i_riscv_mstage_wdata       (wdata),
        .o_riscv_mstage_stall       (stall),
        .o_riscv_mstage_rdata       (rdata),
        .o_riscv_mstage_rdata_valid (rdata_valid),
        .o_riscv_mstage_misaligned  (misaligned),
        .o_riscv_dmem_req           (req),
        .o_riscv_dmem_we            (we),
        .o_riscv_dmem_addr          (dmem_addr),
        .o_riscv_dmem_wdata         (dmem_wdata),
        .o_riscv_dmem_bytemask      (bytemask),
        .i_riscv_dmem_gnt           (gnt),
        .i_riscv_dmem_rvalid        (rvalid),
        .i_riscv_dmem_rdata         (dmem_rdata)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] mem;
        int          gnt_delay;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic        exp_we;
        logic [63:0] exp_rdata;
        int          exp_stall;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] last_load;

    function automatic vec_t mk(input string tag, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] mem,
                                input int gd, input logic [63:0] ea,
                                input logic [63:0] ewd, input logic [7:0] em,
                                input logic ewe, input logic [63:0] erd, input int es);
        vec_t v;
        v.tag = tag; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
        v.mem = mem; v.gnt_delay = gd; v.exp_addr = ea; v.exp_wdata = ewd;
        v.exp_mask = em; v.exp_we = ewe; v.exp_rdata = erd; v.exp_stall = es;
        return v;
    endfunction

    // driver + responder for one complete memory op
    task automatic do_op(input vec_t v);
        int  req_cycles = 0;
        int  stall_cnt  = 0;
        bit  granted    = 0;
        bit  rv_sent    = 0;
        bit  done       = 0;
        bit  first      = 1;
        @(negedge clk);
        valid = 1'b1; memread = v.rd; memwrite = v.wr; funct3 = v.f3;
        addr = v.a; wdata = v.wd; dmem_rdata = v.mem;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (first) begin
                check({v.tag, " misaligned"}, {63'd0, misaligned}, 64'd0);
                first = 0;
            end
            if (stall) stall_cnt++;
            gnt = 1'b0;
            rvalid = 1'b0;
            if (req) begin
                req_cycles++;
                check({v.tag, " addr"}, dmem_addr, v.exp_addr);
                check({v.tag, " mask"}, {56'd0, bytemask}, {56'd0, v.exp_mask});
                check({v.tag, " wdata"}, dmem_wdata, v.exp_wdata);
                check({v.tag, " we"}, {63'd0, we}, {63'd0, v.exp_we});
                if (req_cycles > v.gnt_delay) begin
                    gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted && !rv_sent && !v.exp_we) begin
                rvalid = 1'b1;
                rv_sent = 1;
            end
            if (!stall) begin
                done = 1;
                check({v.tag, " rdata_valid"}, {63'd0, rdata_valid}, {63'd0, !v.exp_we});
                if (!v.exp_we) begin
                    check({v.tag, " rdata"}, rdata, v.exp_rdata);
                    last_load = v.exp_rdata;
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check({v.tag, " timeout"}, 64'd1, 64'd0);
        check({v.tag, " stall cycles"}, 64'(stall_cnt), 64'(v.exp_stall));
        check({v.tag, " req cycles"}, 64'(req_cycles), 64'(v.gnt_delay + 1));
        @(posedge clk);
        #1;
        valid = 1'b0; memread = 1'b0; memwrite = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        check({v.tag, " no reissue req"}, {63'd0, req}, 64'd0);
        check({v.tag, " strobe 1 cycle"}, {63'd0, rdata_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b011;
        addr = '0; wdata = '0; gnt = 1'b0; rvalid = 1'b0; dmem_rdata = '0;
        last_load = '0;

        vecs.push_back(mk("sd",    0, 1, 3'b011, 64'h0,   64'h100000, 64'h0, 0,
                          64'h0,   64'h100000, 8'hFF, 1, 64'h0, 2));
        vecs.push_back(mk("ld",    1, 0, 3'b011, 64'h0,   64'h0, 64'h100000, 0,
                          64'h0,   64'h0, 8'hFF, 0, 64'h100000, 3));
        vecs.push_back(mk("lb",    1, 0, 3'b000, 64'h13,  64'h0, 64'h80000000, 0,
                          64'h10,  64'h0, 8'h08, 0, 64'hFFFFFFFF_FFFFFF80, 3));
        vecs.push_back(mk("lbu",   1, 0, 3'b100, 64'h13,  64'h0, 64'h80000000, 0,
                          64'h10,  64'h0, 8'h08, 0, 64'h80, 3));
        vecs.push_back(mk("sh",    0, 1, 3'b001, 64'h6,   64'hABCD, 64'h0, 3,
                          64'h0,   64'hABCD0000_00000000, 8'hC0, 1, 64'h0, 5));
        vecs.push_back(mk("lhu",   1, 0, 3'b101, 64'h1A,  64'h0, 64'hDEADBEEF_CAFEF00D, 1,
                          64'h18,  64'h0, 8'h0C, 0, 64'hCAFE, 4));
        vecs.push_back(mk("sw",    0, 1, 3'b010, 64'h24,  64'hFFFFFFFF_12345678, 64'h0, 0,
                          64'h20,  64'h12345678_00000000, 8'hF0, 1, 64'h0, 2));
        vecs.push_back(mk("lwu",   1, 0, 3'b110, 64'h0C,  64'h0, 64'h87654321_00000000, 2,
                          64'h08,  64'h0, 8'hF0, 0, 64'h87654321, 5));
        vecs.push_back(mk("sb",    0, 1, 3'b000, 64'h107, 64'h11223344_556677A5, 64'h0, 0,
                          64'h100, 64'hA5000000_00000000, 8'h80, 1, 64'h0, 2));
        vecs.push_back(mk("lh",    1, 0, 3'b001, 64'h6,   64'h0, 64'h80010000_00000000, 0,
                          64'h0,   64'h0, 8'hC0, 0, 64'hFFFFFFFF_FFFF8001, 3));
`ifndef RISCV_MSTAGE_MISALIGN_CHK_EN
        vecs.push_back(mk("lw@2",  1, 0, 3'b010, 64'h2,   64'h0, 64'h11223344_8899AABB, 0,
                          64'h0,   64'h0, 8'h0F, 0, 64'hFFFFFFFF_8899AABB, 3));
`endif
        vecs.push_back(mk("rd+wr", 1, 1, 3'b011, 64'h48,  64'h5555, 64'h0, 0,
                          64'h48,  64'h5555, 8'hFF, 1, 64'h0, 2));

        // stall forced low while reset is high, even with an op present
        @(negedge clk);
        #1;
        check("stall during rst", {63'd0, stall}, 64'd0);
        @(negedge clk);
        valid = 1'b0; memread = 1'b0;
        rst = 1'b0;
        #1;
        check("rst req",         {63'd0, req}, 64'd0);
        check("rst we",          {63'd0, we}, 64'd0);
        check("rst addr",        dmem_addr, 64'd0);
        check("rst wdata",       dmem_wdata, 64'd0);
        check("rst mask",        {56'd0, bytemask}, 64'd0);
        check("rst rdata",       rdata, 64'd0);
        check("rst rdata_valid", {63'd0, rdata_valid}, 64'd0);
        check("rst stall",       {63'd0, stall}, 64'd0);

        // memread with valid low is ignored; spurious gnt/rvalid in IDLE ignored
        memread = 1'b1; gnt = 1'b1; rvalid = 1'b1; dmem_rdata = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle stall", {63'd0, stall}, 64'd0);
            check("idle req",   {63'd0, req}, 64'd0);
            check("idle rvld",  {63'd0, rdata_valid}, 64'd0);
            check("idle rdata", rdata, 64'd0);
        end
        memread = 1'b0; gnt = 1'b0; rvalid = 1'b0;

        foreach (vecs[i]) do_op(vecs[i]);

        // last op was a store: load result must be unchanged
        check("rdata held", rdata, last_load);

`ifdef RISCV_MSTAGE_MISALIGN_CHK_EN
        @(negedge clk);
        valid = 1'b1; memread = 1'b1; funct3 = 3'b010; addr = 64'h2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mis flag",  {63'd0, misaligned}, 64'd1);
            check("mis stall", {63'd0, stall}, 64'd0);
            check("mis req",   {63'd0, req}, 64'd0);
            check("mis rvld",  {63'd0, rdata_valid}, 64'd0);
            @(negedge clk);
        end
        valid = 1'b0; memread = 1'b0;
`endif

        // reset while waiting for read data; the late response is dropped
        @(negedge clk);
        valid = 1'b1; memread = 1'b1; funct3 = 3'b011; addr = 64'h0;
        dmem_rdata = 64'hFEED_F00D;
        #1;
        check("rstwait idle stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        #1;
        check("rstwait req", {63'd0, req}, 64'd1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #1;
        check("rstwait wait stall", {63'd0, stall}, 64'd1);
        check("rstwait wait req",   {63'd0, req}, 64'd0);
        rst = 1'b1; rvalid = 1'b1;
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b0; valid = 1'b0; memread = 1'b0;
        #1;
        check("rstwait rvld",  {63'd0, rdata_valid}, 64'd0);
        check("rstwait req2",  {63'd0, req}, 64'd0);
        check("rstwait rdata", rdata, 64'd0);
        check("rstwait stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        check("rstwait rvld later",  {63'd0, rdata_valid}, 64'd0);
        check("rstwait req later",   {63'd0, req}, 64'd0);
        check("rstwait rdata later", rdata, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
